// File: rtl/activation_sequencer.sv
// Initiator-side sequencer for an activation unit: forward pass arg->res,
// and when training is enabled a backward pass err->fbk.
module activation_sequencer #(
  parameter int ARG_W   = 16,
  parameter int RES_W   = 8,
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             inp_stb_i,
  output logic             inp_rdy_o,
  input  logic [ARG_W-1:0] inp_dat_i,
  output logic             arg_stb_o,
  input  logic             arg_rdy_i,
  output logic [ARG_W-1:0] arg_dat_o,
  input  logic             res_stb_i,
  output logic             res_rdy_o,
  input  logic [RES_W-1:0] res_dat_i,
  output logic             out_stb_o,
  input  logic             out_rdy_i,
  output logic [RES_W-1:0] out_dat_o,
  input  logic             dlt_stb_i,
  output logic             dlt_rdy_o,
  input  logic [ERR_W-1:0] dlt_dat_i,
  output logic             err_stb_o,
  input  logic             err_rdy_i,
  output logic [ERR_W-1:0] err_dat_o,
  input  logic             fbk_stb_i,
  output logic             fbk_rdy_o,
  input  logic [ERR_W-1:0] fbk_dat_i,
  output logic             grd_stb_o,
  input  logic             grd_rdy_i,
  output logic [ERR_W-1:0] grd_dat_o,
  output logic             abort_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_RES, S_OUT, S_DLT, S_ERR, S_FBK, S_GRD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic [ARG_W-1:0]   arg_dat_q, arg_dat_d;
  logic [RES_W-1:0]   out_dat_q, out_dat_d;
  logic [ERR_W-1:0]   err_dat_q, err_dat_d;
  logic [ERR_W-1:0]   grd_dat_q, grd_dat_d;
  logic [7:0]         hs_q, hs_d;  // {grd,fbk,err,dlt,out,res,arg,inp}

  // Handshake outputs are registered, so qualify transfers with the registered flags.
  logic tmo;
  assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      arg_dat_q <= '0;
      out_dat_q <= '0;
      err_dat_q <= '0;
      grd_dat_q <= '0;
      hs_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      arg_dat_q <= arg_dat_d;
      out_dat_q <= out_dat_d;
      err_dat_q <= err_dat_d;
      grd_dat_q <= grd_dat_d;
      hs_q      <= hs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    abort_d   = abort_q;
    arg_dat_d = arg_dat_q;
    out_dat_d = out_dat_q;
    err_dat_d = err_dat_q;
    grd_dat_d = grd_dat_q;
    case (state_q)
      S_IDLE: if (inp_stb_i && hs_q[0]) begin
        arg_dat_d = inp_dat_i;
        state_d   = S_ARG;
      end
      S_ARG: if (hs_q[1] && arg_rdy_i) state_d = S_RES;
      S_RES: begin
        if (res_stb_i && hs_q[2]) begin
          out_dat_d = res_dat_i;
          state_d   = S_OUT;
        end else if (tmo) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: if (hs_q[3] && out_rdy_i) state_d = en_i ? S_DLT : S_IDLE;
      S_DLT: if (dlt_stb_i && hs_q[4]) begin
        err_dat_d = dlt_dat_i;
        state_d   = S_ERR;
      end
      S_ERR: if (hs_q[5] && err_rdy_i) state_d = S_FBK;
      S_FBK: begin
        if (fbk_stb_i && hs_q[6]) begin
          grd_dat_d = fbk_dat_i;
          state_d   = S_GRD;
        end else if (tmo) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GRD: if (hs_q[7] && grd_rdy_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hs_d    = '0;
    hs_d[0] = (state_d == S_IDLE);
    hs_d[1] = (state_d == S_ARG);
    hs_d[2] = (state_d == S_RES);
    hs_d[3] = (state_d == S_OUT);
    hs_d[4] = (state_d == S_DLT);
    hs_d[5] = (state_d == S_ERR);
    hs_d[6] = (state_d == S_FBK);
    hs_d[7] = (state_d == S_GRD);
  end

  assign inp_rdy_o = hs_q[0];
  assign arg_stb_o = hs_q[1];
  assign res_rdy_o = hs_q[2];
  assign out_stb_o = hs_q[3];
  assign dlt_rdy_o = hs_q[4];
  assign err_stb_o = hs_q[5];
  assign fbk_rdy_o = hs_q[6];
  assign grd_stb_o = hs_q[7];
  assign arg_dat_o = arg_dat_q;
  assign out_dat_o = out_dat_q;
  assign err_dat_o = err_dat_q;
  assign grd_dat_o = grd_dat_q;
  assign abort_o   = abort_q;

endmodule

// File: tb/tb_activation_sequencer.sv
// Bench for activation_sequencer: the bench plays upstream, downstream and a
// piecewise-linear sigmoid activation unit, checking against a behavioural model.
module tb_activation_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        en_i = 1'b0;
  logic        inp_stb_i = 1'b0, arg_rdy_i = 1'b0, res_stb_i = 1'b0, out_rdy_i = 1'b0;
  logic        dlt_stb_i = 1'b0, err_rdy_i = 1'b0, fbk_stb_i = 1'b0, grd_rdy_i = 1'b0;
  logic [15:0] inp_dat_i = '0, dlt_dat_i = '0, fbk_dat_i = '0;
  logic [7:0]  res_dat_i = '0;
  logic        inp_rdy_o, arg_stb_o, res_rdy_o, out_stb_o, dlt_rdy_o, err_stb_o, fbk_rdy_o, grd_stb_o;
  logic        abort_o;
  logic [15:0] arg_dat_o, err_dat_o, grd_dat_o;
  logic [7:0]  out_dat_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit en_pass = 1'b0;
  logic exp_abort = 1'b0;

  activation_sequencer #(.ARG_W(16), .RES_W(8), .ERR_W(16), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
    .inp_stb_i(inp_stb_i), .inp_rdy_o(inp_rdy_o), .inp_dat_i(inp_dat_i),
    .arg_stb_o(arg_stb_o), .arg_rdy_i(arg_rdy_i), .arg_dat_o(arg_dat_o),
    .res_stb_i(res_stb_i), .res_rdy_o(res_rdy_o), .res_dat_i(res_dat_i),
    .out_stb_o(out_stb_o), .out_rdy_i(out_rdy_i), .out_dat_o(out_dat_o),
    .dlt_stb_i(dlt_stb_i), .dlt_rdy_o(dlt_rdy_o), .dlt_dat_i(dlt_dat_i),
    .err_stb_o(err_stb_o), .err_rdy_i(err_rdy_i), .err_dat_o(err_dat_o),
    .fbk_stb_i(fbk_stb_i), .fbk_rdy_o(fbk_rdy_o), .fbk_dat_i(fbk_dat_i),
    .grd_stb_o(grd_stb_o), .grd_rdy_i(grd_rdy_i), .grd_dat_o(grd_dat_o),
    .abort_o(abort_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Activation unit model: linear sigmoid saturating at +/-2048, derivative s*(1-s).
  function automatic logic [7:0] sig(input logic [15:0] a);
    int v;
    v = $signed(a) / 16 + 128;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v[7:0];
  endfunction

  function automatic logic [15:0] dfb(input logic [15:0] e, input logic [7:0] r);
    longint t;
    t = longint'(e) * longint'(r) * longint'(256 - int'(r));
    t = (t + 32768) >>> 16;
    return t[15:0];
  endfunction

  function automatic int dl(input int md);
    if (md == 0) return 0;
    return int'($urandom_range(0, md));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input int p);
    case (p)
      0: return inp_rdy_o;
      1: return arg_stb_o;
      2: return res_rdy_o;
      3: return out_stb_o;
      4: return dlt_rdy_o;
      5: return err_stb_o;
      6: return fbk_rdy_o;
      7: return grd_stb_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_drive(input int p, input logic v, input logic [15:0] d);
    case (p)
      0: begin inp_stb_i = v; inp_dat_i = d; end
      1: arg_rdy_i = v;
      2: begin res_stb_i = v; res_dat_i = d[7:0]; end
      3: out_rdy_i = v;
      4: begin dlt_stb_i = v; dlt_dat_i = d; end
      5: err_rdy_i = v;
      6: begin fbk_stb_i = v; fbk_dat_i = d; end
      7: grd_rdy_i = v;
      default: ;
    endcase
  endtask

  // One handshake on port p; returns the cycle count right after the transfer edge.
  task automatic hs(input int p, input logic [15:0] d, input int dly, output int c);
    int n;
    if (p == 3) en_i = en_pass;
    repeat (dly) begin
      @(posedge clk_i); #1;
      if (p != 3) en_i = 1'($urandom_range(0, 1));
    end
    set_drive(p, 1'b1, d);
    n = 0;
    while (!get_rdy(p) && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk($sformatf("hs_wait_p%0d", p), 32'(n < 50), 32'd1);
    @(posedge clk_i); #1;
    c = cyc;
    set_drive(p, 1'b0, 16'h0);
  endtask

  task automatic run_pass(input logic [15:0] a, input bit en_v, input logic [15:0] e,
                          input int md, input int hold, input bit lat, output int c0);
    int c[8];
    logic [7:0] r;
    logic [15:0] g;
    r = sig(a);
    g = dfb(e, r);
    en_pass = en_v;
    hs(0, a, dl(md), c[0]);
    chk("arg_dat", arg_dat_o, a);
    hs(1, 16'h0, dl(md), c[1]);
    hs(2, {8'h00, r}, dl(md), c[2]);
    chk("out_dat", out_dat_o, r);
    for (int i = 0; i < hold; i++) begin
      chk("hold_stb_inp", {out_stb_o, inp_rdy_o}, 2'b10);
      chk("hold_dat", out_dat_o, r);
      @(posedge clk_i); #1;
    end
    hs(3, 16'h0, dl(md), c[3]);
    if (en_v) begin
      chk("dlt_after_out", {dlt_rdy_o, inp_rdy_o}, 2'b10);
      hs(4, e, dl(md), c[4]);
      chk("err_dat", err_dat_o, e);
      hs(5, 16'h0, dl(md), c[5]);
      hs(6, g, dl(md), c[6]);
      chk("grd_dat", grd_dat_o, g);
      hs(7, 16'h0, dl(md), c[7]);
    end
    chk("idle_after_pass", {dlt_rdy_o, inp_rdy_o}, 2'b01);
    if (lat) begin
      for (int k = 1; k < (en_v ? 8 : 4); k++) chk($sformatf("lat_%0d", k), c[k] - c[0], k);
    end
    chk("abort", abort_o, exp_abort);
    c0 = c[0];
  endtask

  initial begin
    int c0a, c0b, c0c, cx;
    logic [15:0] a;
    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_hs", {inp_rdy_o, arg_stb_o, res_rdy_o, out_stb_o, dlt_rdy_o, err_stb_o, fbk_rdy_o, grd_stb_o, abort_o}, 9'h0);
    chk("rst_dat", {arg_dat_o, out_dat_o, err_dat_o, grd_dat_o}, 32'h0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_release_inp_rdy", inp_rdy_o, 1'b1);

    // forward only, then training pass with minimum latency
    run_pass(16'h0000, 1'b0, 16'h0, 0, 0, 1'b1, c0a);
    chk("sig_zero", out_dat_o, 8'h80);
    run_pass(16'h07ff, 1'b0, 16'h0, 0, 0, 1'b0, c0a);
    chk("sig_max", out_dat_o, 8'hff);
    run_pass(16'h0000, 1'b1, 16'h00ff, 0, 0, 1'b1, c0a);
    chk("grd_known", grd_dat_o, 16'h0040);
    run_pass(16'h0000, 1'b0, 16'h0, 0, 0, 1'b1, c0b);
    chk("next_inp_en1", c0b - c0a, 8);
    run_pass(16'hf800, 1'b0, 16'h0, 0, 0, 1'b0, c0c);
    chk("next_inp_en0", c0c - c0b, 4);
    chk("sig_min", out_dat_o, 8'h00);
    run_pass(16'h0000, 1'b0, 16'h0, 0, 0, 1'b0, c0c);
    chk("b2b_second", out_dat_o, 8'h80);

    // downstream stall holds the result
    run_pass(16'h0123, 1'b0, 16'h0, 0, 10, 1'b0, cx);

    // stray strobes in IDLE are ignored
    res_stb_i = 1'b1; fbk_stb_i = 1'b1; dlt_stb_i = 1'b1;
    res_dat_i = 8'h5a; fbk_dat_i = 16'hdead; dlt_dat_i = 16'hbeef;
    repeat (3) begin
      chk("stray_ignored", {res_rdy_o, fbk_rdy_o, dlt_rdy_o, inp_rdy_o}, 4'b0001);
      @(posedge clk_i); #1;
    end
    res_stb_i = 1'b0; fbk_stb_i = 1'b0; dlt_stb_i = 1'b0;
    run_pass(16'hfc00, 1'b1, 16'h1234, 0, 0, 1'b0, cx);

    // randomized passes
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      if (i % 3 == 0) a = 16'($urandom_range(0, 4095)) - 16'd2048;
      run_pass(a, 1'($urandom_range(0, 1)), 16'($urandom), 3, 0, 1'b0, cx);
    end

    // result never arrives: timeout after 8 cycles in RES
    hs(0, 16'h0100, 0, cx);
    hs(1, 16'h0, 0, cx);
    for (int k = 1; k <= 8; k++) begin
      chk("to_wait", {res_rdy_o, abort_o}, 2'b10);
      @(posedge clk_i); #1;
    end
    chk("to_abort", {abort_o, res_rdy_o, inp_rdy_o}, 3'b101);
    exp_abort = 1'b1;
    run_pass(16'h0200, 1'b1, 16'h0777, 2, 0, 1'b0, cx);

    // async reset while waiting for feedback
    en_pass = 1'b1;
    hs(0, 16'h0300, 0, cx);
    hs(1, 16'h0, 0, cx);
    hs(2, {8'h00, sig(16'h0300)}, 0, cx);
    hs(3, 16'h0, 0, cx);
    hs(4, 16'h0abc, 0, cx);
    hs(5, 16'h0, 0, cx);
    chk("in_fbk", fbk_rdy_o, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_mid_hs", {inp_rdy_o, arg_stb_o, res_rdy_o, out_stb_o, dlt_rdy_o, err_stb_o, fbk_rdy_o, grd_stb_o, abort_o}, 9'h0);
    exp_abort = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_mid_release", {inp_rdy_o, grd_stb_o, fbk_rdy_o}, 3'b100);
    run_pass(16'hff00, 1'b1, 16'h4000, 1, 0, 1'b0, cx);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
